// File: rtl/hough_vote_accumulator_pkg.sv
// hough_pkg: shared geometry constants, one-hot state encoding and the saturating
// increment used by hough_vote_accumulator (optional feature macro: HOUGH_VOTE_THRESH_EN).
package hough_pkg;

  localparam int RHO_BINS   = 1600;
  localparam int THETA_BINS = 181;
  localparam int MAX_RHO    = 800;   // offset already applied to rho_addr upstream
  localparam int RHO_W      = 11;
  localparam int THETA_W    = 8;
  localparam int VOTE_W     = 9;
  localparam int BIN_IDX_W  = $clog2(RHO_BINS * THETA_BINS);

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_CLEAR = 5'b00010,
    ST_ACCUM = 5'b00100,
    ST_SCAN  = 5'b01000,
    ST_DONE  = 5'b10000
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/hough_vote_accumulator_if.sv
// Vote/frame/result bundle between the Hough sequencer side (master) and the accumulator (slave).
// HOUGH_VOTE_THRESH_EN adds vote_thresh and line_count.
interface hough_vote_accumulator_if #(
  parameter int RHO_W   = hough_pkg::RHO_W,
  parameter int THETA_W = hough_pkg::THETA_W,
  parameter int VOTE_W  = hough_pkg::VOTE_W
);
  logic               clear;
  logic               vote_we;
  logic [RHO_W-1:0]   rho_addr;
  logic [THETA_W-1:0] theta;
  logic               frame_done;
  logic               busy;
  logic               peak_valid;
  logic [RHO_W-1:0]   peak_rho;
  logic [THETA_W-1:0] peak_theta;
  logic [VOTE_W-1:0]  peak_votes;
  logic [15:0]        drop_count;

`ifdef HOUGH_VOTE_THRESH_EN
  logic [VOTE_W-1:0]  vote_thresh;
  logic [15:0]        line_count;

  modport master (
    output clear, vote_we, rho_addr, theta, frame_done, vote_thresh,
    input  busy, peak_valid, peak_rho, peak_theta, peak_votes, drop_count, line_count
  );
  modport slave (
    input  clear, vote_we, rho_addr, theta, frame_done, vote_thresh,
    output busy, peak_valid, peak_rho, peak_theta, peak_votes, drop_count, line_count
  );
`else
  modport master (
    output clear, vote_we, rho_addr, theta, frame_done,
    input  busy, peak_valid, peak_rho, peak_theta, peak_votes, drop_count
  );
  modport slave (
    input  clear, vote_we, rho_addr, theta, frame_done,
    output busy, peak_valid, peak_rho, peak_theta, peak_votes, drop_count
  );
`endif

endinterface

// File: rtl/hough_vote_accumulator_ram.sv
// hough_vote_ram: simple dual-port vote RAM, one synchronous read port (1-cycle latency)
// and one write port shared by the clear sweep and the vote read-modify-write.
module hough_vote_ram #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 1600 * 181,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; the CLEAR sweep initialises it.
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
    rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/hough_vote_accumulator.sv
// hough_vote_accumulator: accumulates Hough votes per (rho, theta) bin and scans for the
// strongest line at frame end. Optional macro HOUGH_VOTE_THRESH_EN adds a thresholded line count.
module hough_vote_accumulator #(
  parameter int RHO_BINS   = hough_pkg::RHO_BINS,
  parameter int THETA_BINS = hough_pkg::THETA_BINS,
  parameter int RHO_W      = hough_pkg::RHO_W,
  parameter int THETA_W    = hough_pkg::THETA_W,
  parameter int VOTE_W     = hough_pkg::VOTE_W
) (
  input  logic                    clock,
  input  logic                    reset,
  hough_vote_accumulator_if.slave bus
);
  import hough_pkg::*;

  localparam int NBINS = RHO_BINS * THETA_BINS;
  localparam int IDX_W = $clog2(NBINS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [31:0]        VOTE_MAX = (32'd1 << VOTE_W) - 32'd1;
  localparam logic [CNT_W-1:0]   LAST_BIN = CNT_W'(NBINS - 1);
  localparam logic [CNT_W-1:0]   N_CNT    = CNT_W'(NBINS);
  localparam logic [CNT_W-1:0]   SCAN_END = CNT_W'(NBINS + 1);
  localparam logic [RHO_W-1:0]   RHO_LAST = RHO_W'(RHO_BINS - 1);

  state_e             state_q, state_d;
  logic               vote_we_q, frame_done_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RHO_W-1:0]   scan_rho_q, scan_rho_d;
  logic [THETA_W-1:0] scan_theta_q, scan_theta_d;
  logic               cmp_valid_q, cmp_valid_d;
  logic [RHO_W-1:0]   cmp_rho_q, cmp_rho_d;
  logic [THETA_W-1:0] cmp_theta_q, cmp_theta_d;
  logic [VOTE_W-1:0]  max_votes_q, max_votes_d;
  logic [RHO_W-1:0]   max_rho_q, max_rho_d;
  logic [THETA_W-1:0] max_theta_q, max_theta_d;
  logic               scan_pend_q, scan_pend_d;
  logic               s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;
  logic               s1_fwd_q, s1_fwd_d;
  logic [VOTE_W-1:0]  s1_fwd_data_q, s1_fwd_data_d;
  logic               busy_q, busy_d;
  logic               peak_valid_q, peak_valid_d;
  logic [RHO_W-1:0]   peak_rho_q, peak_rho_d;
  logic [THETA_W-1:0] peak_theta_q, peak_theta_d;
  logic [VOTE_W-1:0]  peak_votes_q, peak_votes_d;
  logic [15:0]        drop_count_q, drop_count_d;
`ifdef HOUGH_VOTE_THRESH_EN
  logic [VOTE_W-1:0]  thresh_q, thresh_d;
  logic [15:0]        line_cnt_q, line_cnt_d;
  logic [15:0]        line_count_q, line_count_d;
`endif

  logic               vote_rise, fd_rise, in_range, accept, drop;
  logic [IDX_W-1:0]   vote_idx;
  logic [VOTE_W-1:0]  s1_cur, s1_wdata;
  logic               ram_we;
  logic [IDX_W-1:0]   ram_waddr, ram_raddr;
  logic [VOTE_W-1:0]  ram_wdata, ram_rdata;

  assign vote_rise = bus.vote_we & ~vote_we_q;
  assign fd_rise   = bus.frame_done & ~frame_done_q;
  assign in_range  = (32'(bus.rho_addr) < 32'(RHO_BINS)) && (32'(bus.theta) < 32'(THETA_BINS));
  assign vote_idx  = IDX_W'(bus.theta) * IDX_W'(RHO_BINS) + IDX_W'(bus.rho_addr);
  assign accept    = vote_rise && (state_q == ST_ACCUM) && !scan_pend_q && in_range && !bus.clear;
  assign drop      = vote_rise && !accept;

  // A vote reading the bin being written this cycle would see the stale count, so it
  // carries the in-flight write value into its own write stage instead.
  assign s1_cur   = s1_fwd_q ? s1_fwd_data_q : ram_rdata;
  assign s1_wdata = VOTE_W'(sat_inc(32'(s1_cur), VOTE_MAX));

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s1_idx_q;
    ram_wdata = s1_wdata;
    if (state_q == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = cnt_q[IDX_W-1:0];
      ram_wdata = '0;
    end else if (s1_valid_q) begin
      ram_we = 1'b1;
    end
    ram_raddr = (state_q == ST_SCAN) ? cnt_q[IDX_W-1:0] : vote_idx;
  end

  hough_vote_ram #(
    .DATA_W (VOTE_W),
    .DEPTH  (NBINS),
    .ADDR_W (IDX_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // NOTE: every _d gets a default first so no path through this block infers a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    scan_rho_d    = scan_rho_q;
    scan_theta_d  = scan_theta_q;
    cmp_valid_d   = 1'b0;
    cmp_rho_d     = cmp_rho_q;
    cmp_theta_d   = cmp_theta_q;
    max_votes_d   = max_votes_q;
    max_rho_d     = max_rho_q;
    max_theta_d   = max_theta_q;
    scan_pend_d   = scan_pend_q;
    s1_valid_d    = accept;
    s1_idx_d      = vote_idx;
    s1_fwd_d      = accept && s1_valid_q && (vote_idx == s1_idx_q);
    s1_fwd_data_d = s1_wdata;
    peak_valid_d  = peak_valid_q;
    peak_rho_d    = peak_rho_q;
    peak_theta_d  = peak_theta_q;
    peak_votes_d  = peak_votes_q;
    drop_count_d  = (drop && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
`ifdef HOUGH_VOTE_THRESH_EN
    thresh_d      = thresh_q;
    line_cnt_d    = line_cnt_q;
    line_count_d  = line_count_q;
`endif

    unique case (state_q)
      ST_IDLE: ;
      ST_CLEAR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIN) begin
          state_d = ST_ACCUM;
          cnt_d   = '0;
        end
      end
      ST_ACCUM: begin
        if (fd_rise) scan_pend_d = 1'b1;
        // Scan starts only once the last vote write has landed in the RAM.
        if (scan_pend_q && !s1_valid_q) begin
          state_d      = ST_SCAN;
          scan_pend_d  = 1'b0;
          cnt_d        = '0;
          scan_rho_d   = '0;
          scan_theta_d = '0;
          max_votes_d  = '0;
          max_rho_d    = '0;
          max_theta_d  = '0;
`ifdef HOUGH_VOTE_THRESH_EN
          thresh_d     = bus.vote_thresh;
          line_cnt_d   = '0;
`endif
        end
      end
      ST_SCAN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q < N_CNT) begin
          cmp_valid_d = 1'b1;
          cmp_rho_d   = scan_rho_q;
          cmp_theta_d = scan_theta_q;
          if (scan_rho_q == RHO_LAST) begin
            scan_rho_d   = '0;
            scan_theta_d = scan_theta_q + THETA_W'(1);
          end else begin
            scan_rho_d   = scan_rho_q + RHO_W'(1);
          end
        end
        // Strictly greater keeps the lowest index on ties.
        if (cmp_valid_q && (ram_rdata > max_votes_q)) begin
          max_votes_d = ram_rdata;
          max_rho_d   = cmp_rho_q;
          max_theta_d = cmp_theta_q;
        end
`ifdef HOUGH_VOTE_THRESH_EN
        if (cmp_valid_q && (ram_rdata >= thresh_q) && (line_cnt_q != 16'hFFFF))
          line_cnt_d = line_cnt_q + 16'd1;
`endif
        if (cnt_q == SCAN_END) begin
          state_d      = ST_DONE;
          peak_valid_d = 1'b1;
          peak_rho_d   = max_rho_q;
          peak_theta_d = max_theta_q;
          peak_votes_d = max_votes_q;
`ifdef HOUGH_VOTE_THRESH_EN
          line_count_d = line_cnt_q;
`endif
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase

    if (bus.clear) begin
      state_d      = ST_CLEAR;
      cnt_d        = '0;
      scan_pend_d  = 1'b0;
      s1_valid_d   = 1'b0;
      s1_fwd_d     = 1'b0;
      peak_valid_d = 1'b0;
      peak_rho_d   = '0;
      peak_theta_d = '0;
      peak_votes_d = '0;
      drop_count_d = '0;
`ifdef HOUGH_VOTE_THRESH_EN
      line_count_d = '0;
`endif
    end

    busy_d = (state_d == ST_CLEAR) || (state_d == ST_SCAN);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      vote_we_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      cnt_q         <= '0;
      scan_rho_q    <= '0;
      scan_theta_q  <= '0;
      cmp_valid_q   <= 1'b0;
      cmp_rho_q     <= '0;
      cmp_theta_q   <= '0;
      max_votes_q   <= '0;
      max_rho_q     <= '0;
      max_theta_q   <= '0;
      scan_pend_q   <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_idx_q      <= '0;
      s1_fwd_q      <= 1'b0;
      s1_fwd_data_q <= '0;
      busy_q        <= 1'b0;
      peak_valid_q  <= 1'b0;
      peak_rho_q    <= '0;
      peak_theta_q  <= '0;
      peak_votes_q  <= '0;
      drop_count_q  <= '0;
`ifdef HOUGH_VOTE_THRESH_EN
      thresh_q      <= '0;
      line_cnt_q    <= '0;
      line_count_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      vote_we_q     <= bus.vote_we;
      frame_done_q  <= bus.frame_done;
      cnt_q         <= cnt_d;
      scan_rho_q    <= scan_rho_d;
      scan_theta_q  <= scan_theta_d;
      cmp_valid_q   <= cmp_valid_d;
      cmp_rho_q     <= cmp_rho_d;
      cmp_theta_q   <= cmp_theta_d;
      max_votes_q   <= max_votes_d;
      max_rho_q     <= max_rho_d;
      max_theta_q   <= max_theta_d;
      scan_pend_q   <= scan_pend_d;
      s1_valid_q    <= s1_valid_d;
      s1_idx_q      <= s1_idx_d;
      s1_fwd_q      <= s1_fwd_d;
      s1_fwd_data_q <= s1_fwd_data_d;
      busy_q        <= busy_d;
      peak_valid_q  <= peak_valid_d;
      peak_rho_q    <= peak_rho_d;
      peak_theta_q  <= peak_theta_d;
      peak_votes_q  <= peak_votes_d;
      drop_count_q  <= drop_count_d;
`ifdef HOUGH_VOTE_THRESH_EN
      thresh_q      <= thresh_d;
      line_cnt_q    <= line_cnt_d;
      line_count_q  <= line_count_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.peak_valid = peak_valid_q;
  assign bus.peak_rho   = peak_rho_q;
  assign bus.peak_theta = peak_theta_q;
  assign bus.peak_votes = peak_votes_q;
  assign bus.drop_count = drop_count_q;
`ifdef HOUGH_VOTE_THRESH_EN
  assign bus.line_count = line_count_q;
`endif

endmodule

// File: tb/tb_hough_vote_accumulator.sv
// Scoreboard bench for hough_vote_accumulator on a reduced 20 x 10 bin grid; expected
// peaks are queued with each frame and checked by a monitor when peak_valid rises.
module tb_hough_vote_accumulator;

  localparam int RB = 20;
  localparam int TB = 10;
  localparam int RW = 5;
  localparam int TW = 4;
  localparam int VW = 9;
  localparam int N  = RB * TB;

  typedef struct {
    string name;
    int    votes;
    int    rho;
    int    theta;
    int    drop;
  } exp_t;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  hough_vote_accumulator_if #(.RHO_W(RW), .THETA_W(TW), .VOTE_W(VW)) bus_if ();

  hough_vote_accumulator #(
    .RHO_BINS   (RB),
    .THETA_BINS (TB),
    .RHO_W      (RW),
    .THETA_W    (TW),
    .VOTE_W     (VW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_vote(input int r, input int t);
    bus_if.rho_addr = RW'(r);
    bus_if.theta    = TW'(t);
    bus_if.vote_we  = 1'b1;
    tick();
    bus_if.vote_we  = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus_if.busy && k < N + 20) begin
      tick();
      k++;
    end
    if (bus_if.busy) fail("busy_timeout");
  endtask

  task automatic do_clear();
    bus_if.clear = 1'b1;
    tick();
    bus_if.clear = 1'b0;
    wait_idle();
  endtask

  task automatic wait_peak();
    int k = 0;
    while (!bus_if.peak_valid && k < N + 20) begin
      tick();
      k++;
    end
    if (!bus_if.peak_valid) fail("peak_timeout");
    tick(2);
  endtask

  task automatic frame_pulse();
    bus_if.frame_done = 1'b1;
    tick();
    bus_if.frame_done = 1'b0;
  endtask

  task automatic expect_peak(input string name, input int v, input int r, input int t, input int d);
    exp_t e;
    e.name = name; e.votes = v; e.rho = r; e.theta = t; e.drop = d;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation on every rising edge of peak_valid.
  initial begin : monitor
    logic pv_prev;
    exp_t e;
    pv_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        pv_prev = 1'b0;
      end else begin
        if (bus_if.peak_valid && !pv_prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_peak: votes=%0d rho=%0d theta=%0d with no frame queued",
                     bus_if.peak_votes, bus_if.peak_rho, bus_if.peak_theta);
          end else begin
            e = exp_q.pop_front();
            check({e.name, ".votes"}, int'(bus_if.peak_votes), e.votes);
            check({e.name, ".rho"},   int'(bus_if.peak_rho),   e.rho);
            check({e.name, ".theta"}, int'(bus_if.peak_theta), e.theta);
            check({e.name, ".drop"},  int'(bus_if.drop_count), e.drop);
          end
        end
        pv_prev = bus_if.peak_valid;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int cnt;
    int lat;
    reset             = 1'b0;
    bus_if.clear      = 1'b0;
    bus_if.vote_we    = 1'b0;
    bus_if.rho_addr   = '0;
    bus_if.theta      = '0;
    bus_if.frame_done = 1'b0;
`ifdef HOUGH_VOTE_THRESH_EN
    bus_if.vote_thresh = VW'(1);
`endif
    tick(3);
    check("rst.busy",       int'(bus_if.busy),       0);
    check("rst.peak_valid", int'(bus_if.peak_valid), 0);
    check("rst.peak_votes", int'(bus_if.peak_votes), 0);
    check("rst.drop",       int'(bus_if.drop_count), 0);
    reset = 1'b1;
    tick(2);

    // A vote in IDLE is dropped.
    do_vote(2, 2);
    check("idle_drop", int'(bus_if.drop_count), 1);

    // Clear sweep: busy high for exactly one cycle per bin.
    bus_if.clear = 1'b1;
    tick();
    bus_if.clear = 1'b0;
    check("clear.drop_zeroed", int'(bus_if.drop_count), 0);
    cnt = 0;
    for (int k = 0; k < N + 20; k++) begin
      @(negedge clock);
      if (!bus_if.busy) break;
      cnt++;
    end
    check("clear.busy_cycles", cnt, N);
    tick();

    // Empty accumulator, plus scan latency measured from the sampling edge of frame_done.
    expect_peak("empty", 0, 0, 0, 0);
    bus_if.frame_done = 1'b1;
    lat = 0;
    while (!bus_if.peak_valid && lat < N + 20) begin
      @(posedge clock);
      #1;
      lat++;
      bus_if.frame_done = 1'b0;
    end
    checks++;
    if (lat < N + 3 || lat > N + 5) begin
      errors++;
      $display("FAIL scan_latency: got %0d cycles, expected %0d..%0d", lat, N + 3, N + 5);
    end
    tick(2);

    // Three separate pulses to one bin.
    do_clear();
    for (int i = 0; i < 3; i++) begin
      do_vote(9, 4);
      tick(3);
    end
    expect_peak("three_votes", 3, 9, 4, 0);
    frame_pulse();
    wait_peak();

    // Held-high vote_we counts once.
    do_clear();
    bus_if.rho_addr = RW'(10);
    bus_if.theta    = TW'(0);
    bus_if.vote_we  = 1'b1;
    tick(10);
    bus_if.vote_we  = 1'b0;
    tick();
    expect_peak("held_we", 1, 10, 0, 0);
    frame_pulse();
    wait_peak();

    // Back-to-back edges every 2 cycles, tie resolves to the lower rho.
    do_clear();
    for (int i = 0; i < 5; i++) do_vote(6, 7);
    for (int i = 0; i < 5; i++) do_vote(5, 7);
    expect_peak("tie_fwd", 5, 5, 7, 0);
    frame_pulse();
    wait_peak();

    // Saturation, one out-of-range vote and one vote during SCAN.
    do_clear();
    for (int i = 0; i < 600; i++) do_vote(1, 1);
    do_vote(25, 1);
    check("range_drop", int'(bus_if.drop_count), 1);
    expect_peak("saturate", 511, 1, 1, 2);
    frame_pulse();
    tick(20);
    check("scan.busy", int'(bus_if.busy), 1);
    do_vote(3, 3);
    wait_peak();

    // Clear mid-SCAN.
    do_clear();
    do_vote(4, 4);
    frame_pulse();
    tick(50);
    do_vote(3, 3);
    check("midscan.drop", int'(bus_if.drop_count), 1);
    bus_if.clear = 1'b1;
    tick();
    bus_if.clear = 1'b0;
    check("midscan.busy",       int'(bus_if.busy),       1);
    check("midscan.peak_valid", int'(bus_if.peak_valid), 0);
    check("midscan.drop_zero",  int'(bus_if.drop_count), 0);
    wait_idle();
    check("midscan.after_clear_valid", int'(bus_if.peak_valid), 0);

    // Asynchronous reset mid-ACCUM with a vote in flight.
    do_vote(31, 0);
    check("accum.drop_oor", int'(bus_if.drop_count), 1);
    do_vote(2, 3);
    bus_if.rho_addr = RW'(2);
    bus_if.vote_we  = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("areset.busy",       int'(bus_if.busy),       0);
    check("areset.peak_valid", int'(bus_if.peak_valid), 0);
    check("areset.peak_votes", int'(bus_if.peak_votes), 0);
    check("areset.peak_rho",   int'(bus_if.peak_rho),   0);
    check("areset.peak_theta", int'(bus_if.peak_theta), 0);
    check("areset.drop",       int'(bus_if.drop_count), 0);
    bus_if.vote_we = 1'b0;
    tick(2);
    reset = 1'b1;
    tick();

    // Last theta row, including the very last bin.
    do_clear();
    do_vote(19, 9);
    do_vote(19, 9);
    do_vote(0, 9);
    expect_peak("last_bin", 2, 19, 9, 0);
    frame_pulse();
    wait_peak();

    tick(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hough_vote_accumulator.md
Name: hough_vote_accumulator

Overview:
- Downstream of the Hough transform sequencer. Consumes its per-(rho, theta) vote strobes and accumulates vote counts in an on-chip RAM of RHO_BINS x THETA_BINS bins.
- When the sequencer signals frame completion, scans all bins and reports the single strongest line (rho, theta, votes).
- Frame bracketing: software or a top FSM pulses clear before each frame.

Parameters:
- RHO_BINS, 1600, number of rho bins; rho_addr is already offset by +800 upstream.
- THETA_BINS, 181, number of theta bins (0..180 degrees).
- RHO_W, 11, width of rho_addr.
- THETA_W, 8, width of theta.
- VOTE_W, 9, width of one vote counter; saturates at 2^VOTE_W-1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- clear  in  1  single-cycle strobe; starts zeroing of all bins
- vote_we  in  1  upstream write_enable (level); a vote is taken on each 0->1 transition
- rho_addr  in  RHO_W  rho bin of the vote, sampled on the vote_we rising cycle
- theta  in  THETA_W  theta bin of the vote, sampled with rho_addr
- frame_done  in  1  upstream ready (level); a 0->1 transition starts the peak scan
- busy  out  1  high in CLEAR and SCAN
- peak_valid  out  1  high from scan completion until next clear or reset
- peak_rho  out  RHO_W  rho bin of the maximum
- peak_theta  out  THETA_W  theta bin of the maximum
- peak_votes  out  VOTE_W  vote count of the maximum
- drop_count  out  16  votes discarded (out of range, or arriving in CLEAR/SCAN/DONE); saturating

Behaviour:
- Reset: state=IDLE; busy, peak_valid, peak_rho, peak_theta, peak_votes and drop_count = 0. RAM contents are undefined after reset; a clear is required before the first frame.
- Bin index = theta*RHO_BINS + rho_addr, computed with unsigned arithmetic of width ceil(log2(RHO_BINS*THETA_BINS)) (19 bits).
- States:
  - IDLE: waiting.
  - CLEAR: writes 0 to one bin per cycle, RHO_BINS*THETA_BINS cycles, then goes to ACCUM.
  - ACCUM: accepts votes.
  - SCAN: reads one bin per cycle, then goes to DONE.
  - DONE: holds the result.
- Transitions:
  - clear in any state (including mid-SCAN) -> CLEAR; this also drops peak_valid and zeroes drop_count.
  - frame_done rise in ACCUM -> SCAN, entered only after the RMW pipeline has drained (at most 2 cycles).
  - frame_done rise in any other state is ignored.
- Vote edge-detect: a vote is taken when vote_we=1 and vote_we was 0 in the previous cycle. A held-high vote_we counts exactly once.
- Vote RMW pipeline, 2 stages:
  - Cycle 0: read bin.
  - Cycle 1: write bin+1, saturating at 2^VOTE_W-1.
  - If a new vote hits the bin currently being written, the in-flight value is forwarded, so no vote is lost. This covers back-to-back edges as fast as every 2 cycles.
- Range check: a vote with rho_addr>=RHO_BINS or theta>=THETA_BINS is not written and increments drop_count. A vote arriving outside ACCUM also increments drop_count.
- Scan:
  - Reads run in index order; RAM read latency is 1 cycle.
  - The running max is replaced only on a strictly greater count, so on a tie the lowest index (lowest theta, then lowest rho) wins.
  - Scan latency = RHO_BINS*THETA_BINS+2 cycles from entering SCAN to peak_valid=1.
  - An all-zero accumulator reports peak_votes=0, peak_rho=0, peak_theta=0, peak_valid=1.
- Peak outputs change only at scan completion and are zeroed on clear.
- Reset mid-operation returns to IDLE immediately; any partial RMW write is abandoned.

Optional Feature:
- Macro: HOUGH_VOTE_THRESH_EN.
- Defined: adds input vote_thresh [VOTE_W-1:0], sampled on SCAN entry, and output line_count [15:0], the number of bins with count >= vote_thresh, counted during the scan. line_count is valid with peak_valid, zeroed on clear, and saturates.
- Undefined: neither port exists and there is no extra logic.

Decomposition:
- Package hough_pkg holds:
  - RHO_BINS, THETA_BINS and the MAX_RHO offset 800.
  - The bin-index width constant.
  - The state encoding (one-hot, 5 states).
  - The saturating-increment function.
- Sub-module hough_vote_ram: simple dual-port RAM with one synchronous read port and one write port, VOTE_W x RHO_BINS*THETA_BINS. The write port is shared by CLEAR and the RMW stage.

Test Plan:
- Reset then clear: busy stays high for exactly 289600 cycles, then ACCUM. A scan with no votes gives peak_valid=1, peak_votes=0, peak_rho=0, peak_theta=0.
- Three separate vote_we pulses at (rho=900, theta=45), then frame_done rise: peak_rho=900, peak_theta=45, peak_votes=3, drop_count=0.
- vote_we held high for 10 cycles at (rho=10, theta=0): counted once, peak_votes=1.
- Pulses spaced 2 cycles apart, 5 at (rho=5, theta=7) and 5 at (rho=6, theta=7): exercises forwarding. Tie resolved to peak_rho=5, peak_votes=5.
- 600 votes to (rho=1, theta=1) with VOTE_W=9: saturates at peak_votes=511. A vote with rho_addr=1700 and one during SCAN each raise drop_count, giving final drop_count=2.
- clear asserted mid-SCAN: re-enters CLEAR, peak_valid stays 0 and drop_count=0. Asynchronous reset mid-ACCUM: all outputs 0 in the same cycle.
